tx_write_arbiter: RTL and testbench
===================================

# tx_write_arbiter

Round-robin arbiter that shares the single transmit-FIFO write port among N_SRC producers. Each producer signals a new word with a rising edge on its data-available line. The arbiter captures the word into a one-deep holding slot per source and issues one-cycle `fifo_wrreq` pulses, one word per cycle, while the FIFO is not full. It sits between the producer blocks and the TX FIFO, replacing the per-source edge-to-wrreq logic.

## Interface
- `N_SRC`, default 4: number of producers (2..8).
- `DATA_W`, default 8: word width.
- `Mclk` in 1: system clock; all state updates on the falling edge.
- `nReset` in 1: asynchronous, active-low reset.
- `Data_Available` in N_SRC: per-source level; a 0→1 transition is one word event.
- `src_data` in N_SRC*DATA_W: source i occupies bits [i*DATA_W +: DATA_W].
- `fifo_full` in 1: TX FIFO full flag.
- `clr_ovf` in 1: synchronous clear of `ovf_flags`.
- `fifo_wrreq` out 1: write strobe, at most one cycle per word.
- `fifo_data` out DATA_W: word accompanying `fifo_wrreq`.
- `grant_id` out clog2(N_SRC): source index of the current/last write.
- `pending` out N_SRC: holding-slot occupied flags.
- `ovf_flags` out N_SRC: sticky per-source overflow (event dropped).

## Operation
- Edge detect per source: `old_da[i]` registers `Data_Available[i]` each falling edge. An event is `Data_Available[i] & ~old_da[i]`.
- On an event with `pending[i]`=0, or with `pending[i]`=1 and source i granted in that same cycle:
  - capture `src_data[i]` into `hold[i]`;
  - set `pending[i]`.
- On an event with `pending[i]`=1 and source i not granted: the word is dropped, `hold[i]` is unchanged, and `ovf_flags[i]` is set.
- Arbitration, each cycle with `fifo_full`=0 and any `pending` bit set:
  - grant the first pending index at or after `rr_ptr`, wrapping modulo N_SRC;
  - register `fifo_wrreq`=1, `fifo_data`=`hold[g]`, `grant_id`=g;
  - clear `pending[g]`;
  - set `rr_ptr` to (g+1) mod N_SRC.
- With `fifo_full`=1 or nothing pending: `fifo_wrreq`=0; `fifo_data`/`grant_id` hold their last values; `rr_ptr` is unchanged.
- `clr_ovf`=1 clears all `ovf_flags` bits. A same-cycle overflow event wins, so that bit stays set.
- Controller FSM:
  - IDLE (nothing pending) → ARB when any `pending` bit is set.
  - ARB → STALL when `fifo_full`=1 with pending work; STALL → ARB when `fifo_full`=0.
  - ARB → IDLE when the last pending bit clears with no new event.
  - The FSM drives the `grant_enable` qualifier and a debug state output is not required.

## Timing
- Reset values, asserted asynchronously on `nReset`=0:
  - `fifo_wrreq`=0, `fifo_data`=0, `grant_id`=0, `pending`=0, `ovf_flags`=0;
  - `old_da`=0, `rr_ptr`=0, FSM=IDLE.
- A source already high at reset release therefore produces one event.
- Latency: an event sampled at falling edge k sets `pending` at k. The earliest `fifo_wrreq` is registered at falling edge k+1 and is high until k+2.
- `fifo_wrreq` is registered on the falling edge, so it is stable at the FIFO's rising-edge sample.
- `fifo_full` is sampled at the same falling edge that would register the grant. No write is issued in a cycle where `fifo_full` was 1.
- Throughput: one word per cycle; N_SRC simultaneous events drain in N_SRC cycles.
- Reset mid-operation: all pending words are discarded, and no partial `fifo_wrreq` pulse may be extended.

## Structure
- Shared package `tx_pkg`:
  - FSM state enum `{IDLE, ARB, STALL}`;
  - `TX_DATA_W`=8;
  - `clog2` helper.
- Sub-module `rr_pick`: combinational first-set-at-or-after-pointer search (inputs `pending`, `rr_ptr`; outputs `valid`, `idx`). It is instantiated once.
- Holding registers and edge detectors stay in the top module.

## Test plan
- Single event: source 2 rises with `src_data`=0xA5, `fifo_full`=0 → one `fifo_wrreq` pulse exactly 1 cycle after the edge, `fifo_data`=0xA5, `grant_id`=2, `pending`=0 afterwards.
- Simultaneous events: all 4 sources rise with 0x10/0x11/0x12/0x13 in one cycle, `rr_ptr`=0 → 4 consecutive pulses with data 0x10,0x11,0x12,0x13; then source 1 alone → granted next.
- Backpressure: 2 pending, `fifo_full`=1 for 5 cycles → no wrreq during those cycles, FSM=STALL; `fifo_full` drops → 2 pulses on consecutive cycles, order preserved by `rr_ptr`.
- Overflow: source 0 edges twice while `fifo_full`=1 (data 0x01 then 0x02) → `ovf_flags[0]`=1; after release, 0x01 is written, 0x02 is never written; `clr_ovf` pulse → `ovf_flags`=0.
- Same-cycle grant and re-event: source 3 is granted (0x20) as a new edge arrives with 0x21 → 0x20 written, `pending[3]` stays 1, 0x21 written next, `ovf_flags[3]`=0.
- Async reset mid-drain: `nReset` low between falling edges while 3 words are pending → outputs are 0 immediately; after release with all `Data_Available` held high → exactly one event per source.

Source files
------------

// File: rtl/tx_write_arbiter_pkg.sv
// Shared types and constants for the transmit-FIFO write arbiter.
package tx_pkg;

    localparam int TX_DATA_W = 8;

    // Controller states: IDLE (nothing held), ARB (granting), STALL (FIFO full).
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        STALL = 2'd2
    } tx_state_e;

    // Ceiling log2 for elaboration-time widths; clog2(1) returns 0.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tx_write_arbiter_if.sv
// Producer/FIFO-side bundle of the write arbiter. The arbiter uses the
// slave view; the producers and the FIFO together form the master view.
interface tx_write_arbiter_if
    import tx_pkg::*;
#(
    parameter int N_SRC  = 4,
    parameter int DATA_W = TX_DATA_W
);
    localparam int IDX_W = clog2(N_SRC);

    logic [N_SRC-1:0]        Data_Available;
    logic [N_SRC*DATA_W-1:0] src_data;
    logic                    fifo_full;
    logic                    clr_ovf;
    logic                    fifo_wrreq;
    logic [DATA_W-1:0]       fifo_data;
    logic [IDX_W-1:0]        grant_id;
    logic [N_SRC-1:0]        pending;
    logic [N_SRC-1:0]        ovf_flags;

    modport master (
        output Data_Available, src_data, fifo_full, clr_ovf,
        input  fifo_wrreq, fifo_data, grant_id, pending, ovf_flags
    );

    modport slave (
        input  Data_Available, src_data, fifo_full, clr_ovf,
        output fifo_wrreq, fifo_data, grant_id, pending, ovf_flags
    );

endinterface

// File: rtl/tx_write_arbiter_rr_pick.sv
// Round-robin search: first set bit of pending at or after rr_ptr, wrapping.
module rr_pick #(
    parameter int N_SRC = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_SRC-1:0] pending,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Walk the offsets from the pointer; the first hit wins.
    always_comb begin
        // NOTE: every output gets a default before the search so no path
        // leaves it unassigned, which would otherwise infer a latch.
        valid = 1'b0;
        idx   = '0;
        for (int off = 0; off < N_SRC; off++) begin
            logic [IDX_W-1:0] cand;
            cand = IDX_W'((int'(rr_ptr) + off) % N_SRC);
            if (!valid && pending[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/tx_write_arbiter.sv
// Shares the single TX-FIFO write port among N_SRC edge-signalled producers.
// Every register updates on the falling edge of Mclk so that fifo_wrreq and
// fifo_data are settled when the FIFO samples on the rising edge.
module tx_write_arbiter
    import tx_pkg::*;
#(
    parameter int N_SRC  = 4,
    parameter int DATA_W = TX_DATA_W
) (
    input  logic                Mclk,
    input  logic                nReset,
    tx_write_arbiter_if.slave   bus
);

    localparam int IDX_W = clog2(N_SRC);

    logic [N_SRC-1:0]  old_da_q;
    logic [N_SRC-1:0]  da_event;
    logic [N_SRC-1:0]  pending_q, pending_d;
    logic [N_SRC-1:0]  ovf_q, ovf_d;
    logic [N_SRC-1:0]  grant_vec;
    logic [DATA_W-1:0] hold_q [N_SRC];
    logic [DATA_W-1:0] hold_d [N_SRC];
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  grant_id_q, grant_id_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wrreq_q, wrreq_d;
    logic              pick_valid;
    logic              grant_enable;
    logic              do_grant;
    tx_state_e         state_q, state_d;

    assign da_event = bus.Data_Available & ~old_da_q;
    assign do_grant = pick_valid & grant_enable;

    rr_pick #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .pending (pending_q),
        .rr_ptr  (rr_ptr_q),
        .valid   (pick_valid),
        .idx     (pick_idx)
    );

    // Grant qualifier: a non-full FIFO permits a write in every state. IDLE
    // must allow it so a word captured at edge k is written at edge k+1, and
    // STALL lets the grant through on the same edge that fifo_full drops.
    always_comb begin
        grant_enable = 1'b0;
        case (state_q)
            IDLE, ARB, STALL: grant_enable = ~bus.fifo_full;
            default:          grant_enable = 1'b0;
        endcase
    end

    // Controller next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|pending_q) state_d = ARB;
            ARB: begin
                if (bus.fifo_full && |pending_q) state_d = STALL;
                else if (pending_d == '0)        state_d = IDLE;
            end
            STALL:   if (!bus.fifo_full) state_d = ARB;
            default: state_d = IDLE;
        endcase
    end

    // Slot capture, grant clear and sticky overflow. A source granted this
    // cycle frees its slot, so a coincident new word is captured, not dropped.
    always_comb begin
        grant_vec = '0;
        if (do_grant) grant_vec[pick_idx] = 1'b1;
        pending_d = pending_q & ~grant_vec;
        ovf_d     = bus.clr_ovf ? '0 : ovf_q;
        hold_d    = hold_q;
        for (int i = 0; i < N_SRC; i++) begin
            if (da_event[i]) begin
                if (!pending_q[i] || grant_vec[i]) begin
                    hold_d[i]    = bus.src_data[i*DATA_W +: DATA_W];
                    pending_d[i] = 1'b1;
                end else begin
                    ovf_d[i] = 1'b1;
                end
            end
        end
    end

    // Write strobe, data/grant hold and pointer advance past the winner.
    always_comb begin
        wrreq_d    = do_grant;
        data_d     = data_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        if (do_grant) begin
            data_d     = hold_q[pick_idx];
            grant_id_d = pick_idx;
            rr_ptr_d   = (pick_idx == IDX_W'(N_SRC - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

    // Control and output registers, cleared asynchronously by nReset.
    always_ff @(negedge Mclk or negedge nReset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!nReset) begin
            old_da_q   <= '0;
            pending_q  <= '0;
            ovf_q      <= '0;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            data_q     <= '0;
            wrreq_q    <= 1'b0;
            state_q    <= IDLE;
        end else begin
            old_da_q   <= bus.Data_Available;
            pending_q  <= pending_d;
            ovf_q      <= ovf_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            data_q     <= data_d;
            wrreq_q    <= wrreq_d;
            state_q    <= state_d;
        end
    end

    // Holding slots, written only on capture.
    always_ff @(negedge Mclk) begin
        // NOTE: the slots have no reset; a slot is only read while its
        // pending bit is set, and that bit is cleared by reset.
        hold_q <= hold_d;
    end

    assign bus.fifo_wrreq = wrreq_q;
    assign bus.fifo_data  = data_q;
    assign bus.grant_id   = grant_id_q;
    assign bus.pending    = pending_q;
    assign bus.ovf_flags  = ovf_q;

endmodule

// File: tb/tb_tx_write_arbiter.sv
// Directed bench for tx_write_arbiter. Inputs change and outputs are sampled
// 1 ns after the rising edge, half a period away from the active falling edge.
module tb_tx_write_arbiter;
    import tx_pkg::*;

    localparam int N = 4;
    localparam int W = 8;

    logic Mclk   = 1'b1;
    logic nReset = 1'b0;
    always #5 Mclk = ~Mclk;

    tx_write_arbiter_if #(.N_SRC(N), .DATA_W(W)) bus ();

    tx_write_arbiter #(.N_SRC(N), .DATA_W(W)) dut (
        .Mclk   (Mclk),
        .nReset (nReset),
        .bus    (bus)
    );

    logic [W-1:0] sd [N];
    assign bus.src_data = {sd[3], sd[2], sd[1], sd[0]};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past one falling edge and land 1 ns after the next rising edge.
    task automatic step();
        @(negedge Mclk);
        @(posedge Mclk);
        #1;
    endtask

    task automatic expect_write(input string tag, input logic [7:0] d, input logic [1:0] g);
        check({tag, ".wrreq"}, 32'(bus.fifo_wrreq), 32'd1);
        check({tag, ".data"},  32'(bus.fifo_data),  32'(d));
        check({tag, ".gid"},   32'(bus.grant_id),   32'(g));
    endtask

    task automatic expect_idle(input string tag);
        check({tag, ".wrreq"}, 32'(bus.fifo_wrreq), 32'd0);
    endtask

    task automatic expect_all_zero(input string tag);
        check({tag, ".wrreq"},   32'(bus.fifo_wrreq), 32'd0);
        check({tag, ".data"},    32'(bus.fifo_data),  32'd0);
        check({tag, ".gid"},     32'(bus.grant_id),   32'd0);
        check({tag, ".pending"}, 32'(bus.pending),    32'd0);
        check({tag, ".ovf"},     32'(bus.ovf_flags),  32'd0);
    endtask

    task automatic do_reset();
        nReset = 1'b0;
        step();
        nReset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.Data_Available = '0;
        bus.fifo_full      = 1'b0;
        bus.clr_ovf        = 1'b0;
        for (int i = 0; i < N; i++) sd[i] = '0;

        #1;
        expect_all_zero("reset");
        step();
        nReset = 1'b1;

        // Single event on source 2.
        bus.Data_Available = 4'b0100;
        sd[2] = 8'hA5;
        step();
        check("single.pending_k", 32'(bus.pending), 32'h4);
        expect_idle("single.k");
        step();
        expect_write("single.k1", 8'hA5, 2'd2);
        check("single.pending_after", 32'(bus.pending), 32'h0);
        bus.Data_Available = '0;
        step();
        expect_idle("single.k2");

        // Four simultaneous events from rr_ptr = 0, then source 1 alone.
        do_reset();
        bus.Data_Available = 4'b1111;
        sd[0] = 8'h10; sd[1] = 8'h11; sd[2] = 8'h12; sd[3] = 8'h13;
        step();
        check("simul.pending", 32'(bus.pending), 32'hF);
        for (int i = 0; i < N; i++) begin
            step();
            expect_write($sformatf("simul.w%0d", i), 8'(8'h10 + i), 2'(i));
        end
        check("simul.pending_after", 32'(bus.pending), 32'h0);
        bus.Data_Available = '0;
        step();
        expect_idle("simul.gap");
        bus.Data_Available = 4'b0010;
        sd[1] = 8'h31;
        step();
        step();
        expect_write("simul.src1", 8'h31, 2'd1);
        bus.Data_Available = '0;
        step();

        // Backpressure: sources 0 and 3 pending, rr_ptr = 2, FIFO full 5 cycles.
        bus.fifo_full = 1'b1;
        bus.Data_Available = 4'b1001;
        sd[0] = 8'h40; sd[3] = 8'h43;
        step();
        check("bp.pending", 32'(bus.pending), 32'h9);
        for (int i = 0; i < 5; i++) begin
            step();
            expect_idle($sformatf("bp.stall%0d", i));
        end
        check("bp.state",      32'(dut.state_q),   32'(STALL));
        check("bp.gid_held",   32'(bus.grant_id),  32'd1);
        check("bp.data_held",  32'(bus.fifo_data), 32'h31);
        bus.fifo_full = 1'b0;
        bus.Data_Available = '0;
        step();
        expect_write("bp.first", 8'h43, 2'd3);
        step();
        expect_write("bp.second", 8'h40, 2'd0);
        step();
        expect_idle("bp.done");

        // Overflow: source 0 edges twice while the FIFO is full.
        bus.fifo_full = 1'b1;
        bus.Data_Available = 4'b0001;
        sd[0] = 8'h01;
        step();
        check("ovf.pending", 32'(bus.pending), 32'h1);
        bus.Data_Available = '0;
        step();
        bus.Data_Available = 4'b0001;
        sd[0] = 8'h02;
        step();
        check("ovf.flag_set", 32'(bus.ovf_flags), 32'h1);
        bus.Data_Available = '0;
        bus.fifo_full = 1'b0;
        step();
        expect_write("ovf.kept", 8'h01, 2'd0);
        step();
        expect_idle("ovf.dropped");
        check("ovf.pending_after", 32'(bus.pending),   32'h0);
        check("ovf.flag_sticky",   32'(bus.ovf_flags), 32'h1);
        bus.clr_ovf = 1'b1;
        step();
        bus.clr_ovf = 1'b0;
        check("ovf.cleared", 32'(bus.ovf_flags), 32'h0);

        // Same-cycle grant of source 3 and a new edge on source 3.
        bus.fifo_full = 1'b1;
        bus.Data_Available = 4'b1000;
        sd[3] = 8'h20;
        step();
        bus.Data_Available = '0;
        step();
        bus.fifo_full = 1'b0;
        bus.Data_Available = 4'b1000;
        sd[3] = 8'h21;
        step();
        expect_write("same.first", 8'h20, 2'd3);
        check("same.pending", 32'(bus.pending),   32'h8);
        check("same.ovf",     32'(bus.ovf_flags), 32'h0);
        bus.Data_Available = '0;
        step();
        expect_write("same.second", 8'h21, 2'd3);
        check("same.pending_after", 32'(bus.pending), 32'h0);
        step();
        expect_idle("same.done");

        // Asynchronous reset mid-drain, with a write strobe high.
        bus.Data_Available = 4'b1111;
        sd[0] = 8'h50; sd[1] = 8'h51; sd[2] = 8'h52; sd[3] = 8'h53;
        step();
        step();
        expect_write("rst.pre", 8'h50, 2'd0);
        check("rst.pre_pending", 32'(bus.pending), 32'hE);
        #2 nReset = 1'b0;
        #1;
        expect_all_zero("rst.async");
        step();
        expect_all_zero("rst.held");
        nReset = 1'b1;
        step();
        check("rst.events", 32'(bus.pending), 32'hF);
        expect_idle("rst.events");
        for (int i = 0; i < N; i++) begin
            step();
            expect_write($sformatf("rst.w%0d", i), 8'(8'h50 + i), 2'(i));
        end
        for (int i = 0; i < 3; i++) begin
            step();
            expect_idle($sformatf("rst.tail%0d", i));
        end
        check("rst.pending_after", 32'(bus.pending), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
